// File: rtl/fm_stream_tx.sv
// Frame streamer: buffers upstream pixel vectors in a 4-entry FIFO and emits a
// FM_WIDTH x FM_WIDTH frame, one pixel every PIXEL_GAP cycles, framed by sync/done
// pulses. Define UNDERRUN_CNT_EN to add the underrun_cnt output.
module fm_stream_tx #(
  parameter int FM_DEPTH  = 64,
  parameter int FM_WIDTH  = 56,
  parameter int PIXEL_GAP = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*FM_DEPTH-1:0]  in_data,
  output logic                    mode_out,
  output logic                    verticle_sync,
  output logic                    data_out_valid,
  output logic [16*FM_DEPTH-1:0]  data_out,
  output logic                    frame_done,
  output logic                    busy,
`ifdef UNDERRUN_CNT_EN
  output logic [15:0]             underrun_cnt,
`endif
  output logic [2:0]              state_dbg
);

  localparam int DW = 16 * FM_DEPTH;
  localparam int CW = (FM_WIDTH > 1) ? $clog2(FM_WIDTH) : 1;
  localparam int GW = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [CW-1:0] LAST_IDX = CW'(FM_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(PIXEL_GAP - 1);

  // Handshake: a pixel is transferred on any cycle where in_valid && in_ready.
  // in_ready comes only from the registered count, so a full FIFO refuses
  // a push even on a cycle where it also pops.

  logic [DW-1:0]   mem_q [4];
  logic [DW-1:0]   mem_d [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic [2:0]      state_q, state_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   row_q, row_d;
  logic [DW-1:0]   data_q, data_d;
  logic            push;
  logic            emit;
  logic [DW-1:0]   head;

  assign in_ready = (count_q < 3'd4);
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (emit) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, emit})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    col_d   = col_q;
    row_d   = row_q;
    data_d  = data_q;
    emit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        data_d = '0;
        if (start) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        gcnt_d  = '0;
        col_d   = '0;
        row_d   = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GW'(1);
        end else if (count_q != 3'd0) begin
          emit   = 1'b1;
          data_d = head;
          gcnt_d = GAP_LOAD;
          if (col_q == LAST_IDX) begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
              // Last pixel of the frame: reuse gcnt to time the drain.
              row_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (gcnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      gcnt_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      data_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      data_q   <= data_d;
    end
  end

  assign mode_out       = (state_q != ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign verticle_sync  = (state_q == ST_SYNC);
  assign frame_done     = (state_q == ST_DONE);
  assign data_out_valid = emit;
  // The strobed pixel is shown in its own cycle; data_q holds it afterwards.
  assign data_out       = (state_q == ST_IDLE) ? '0 : (emit ? head : data_q);
  assign state_dbg      = state_q;

`ifdef UNDERRUN_CNT_EN
  logic        underrun;
  logic [15:0] ucnt_q, ucnt_d;

  assign underrun = (state_q == ST_STREAM) && (gcnt_q == '0) && (count_q == 3'd0);

  always_comb begin
    ucnt_d = ucnt_q;
    if (state_q == ST_SYNC) begin
      ucnt_d = '0;
    end else if (underrun && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_fm_stream_tx.sv
// Directed bench for fm_stream_tx at FM_WIDTH=4, PIXEL_GAP=8, FM_DEPTH=2:
// FIFO table, full frames, underrun, restart, mid-frame reset, same-cycle start/push.
module tb_fm_stream_tx;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          mode_out;
  logic          verticle_sync;
  logic          data_out_valid;
  logic [W-1:0]  data_out;
  logic          frame_done;
  logic          busy;
  logic [2:0]    state_dbg;
`ifdef UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  fm_stream_tx #(.FM_DEPTH(2), .FM_WIDTH(4), .PIXEL_GAP(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .mode_out       (mode_out),
    .verticle_sync  (verticle_sync),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .frame_done     (frame_done),
    .busy           (busy),
`ifdef UNDERRUN_CNT_EN
    .underrun_cnt   (underrun_cnt),
`endif
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic [W-1:0] data;
    logic         exp_ready;
  } vec_t;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] sdata_q[$];
  int           strobe_q[$];
  logic [W-1:0] last_data;
  int           n_tests;
  int           n_fail;
  int           cyc;
  int           vs_cnt, vs_cyc, vs0;
  int           fd_cnt, fd_cyc, fd0;
  int           next_pix;
  bit           feed_en;
  int           t;

  function automatic logic [W-1:0] pix(input int k);
    return {16'hA000 | 16'(k), 16'h5000 | 16'(k * 3)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: scoreboard the current cycle, then advance and drive the next.
  task automatic step();
    logic acc;
    #2;
    acc = in_valid && in_ready && !rst;
    if (acc) exp_q.push_back(in_data);
    if (data_out_valid) begin
      strobe_q.push_back(cyc);
      sdata_q.push_back(data_out);
      if (exp_q.size() == 0) chk("strobe_unexpected", 1, 0);
      else chk("strobe_data", data_out, exp_q.pop_front());
      last_data = data_out;
    end else if (!mode_out) begin
      chk("data_idle", data_out, 0);
      last_data = '0;
    end else begin
      chk("data_hold", data_out, last_data);
    end
    if (verticle_sync) begin vs_cnt++; vs_cyc = cyc; end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    @(posedge clk);
    cyc++;
    #1;
    start = 1'b0;
    if (feed_en) begin
      if (acc) next_pix++;
      in_valid = 1'b1;
      in_data  = pix(next_pix);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_mode_out"}, mode_out, 0);
    chk({tag, "_vsync"}, verticle_sync, 0);
    chk({tag, "_dvalid"}, data_out_valid, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, state_dbg, 0);
`ifdef UNDERRUN_CNT_EN
    chk({tag, "_ucnt"}, underrun_cnt, 0);
`endif
  endtask

  task automatic begin_frame(output int t0);
    t0 = cyc;
    strobe_q.delete();
    sdata_q.delete();
    vs0 = vs_cnt;
    fd0 = fd_cnt;
    start = 1'b1;
    step();
  endtask

  task automatic finish_frame(input int t0, input int mid_start, input int feed_at);
    while (fd_cnt == fd0 && cyc < t0 + 400) begin
      if (cyc == mid_start) begin
        start = 1'b1;
        chk("restart_in_stream", state_dbg, 2);
      end
      if (cyc == feed_at) begin
        feed_en  = 1'b1;
        in_valid = 1'b1;
        in_data  = pix(next_pix);
      end
      step();
    end
    chk("frame_done_seen", fd_cnt - fd0, 1);
    chk("vsync_once", vs_cnt - vs0, 1);
    chk("idle_after_done", state_dbg, 0);
    chk("mode_after_done", mode_out, 0);
  endtask

  task automatic check_regular(input int t0);
    chk("vsync_cyc", vs_cyc, t0 + 1);
    chk("n_strobes", strobe_q.size(), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < strobe_q.size()) chk("strobe_cyc", strobe_q[k], t0 + 2 + 8 * k);
    end
    chk("done_cyc", fd_cyc, t0 + 131);
  endtask

  initial begin
    vec_t tbl[6];
    n_tests = 0; n_fail = 0; cyc = 0;
    vs_cnt = 0; fd_cnt = 0; vs_cyc = -1; fd_cyc = -1;
    next_pix = 0; feed_en = 1'b0; last_data = '0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();
    step();

    // FIFO fill in IDLE: 4 accepted, 5th refused
    tbl[0] = '{1'b1, 32'h0000_0011, 1'b1};
    tbl[1] = '{1'b1, 32'h0000_0022, 1'b1};
    tbl[2] = '{1'b1, 32'h0000_0033, 1'b1};
    tbl[3] = '{1'b1, 32'h0000_0044, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0055, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0055, 1'b0};
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].valid;
      in_data  = tbl[i].data;
      #1;
      chk("fill_ready", in_ready, tbl[i].exp_ready);
      step();
    end
    chk("idle_busy", busy, 0);

    // Frame 1: preloaded, 5th pixel waits for the first pop, restart ignored
    begin_frame(t);
    chk("f1_sync_vs", verticle_sync, 1);
    chk("f1_sync_state", state_dbg, 1);
    chk("f1_sync_mode", mode_out, 1);
    chk("f1_sync_full", in_ready, 0);
    chk("f1_sync_nostrobe", data_out_valid, 0);
    step();
    chk("f1_first_strobe", data_out_valid, 1);
    chk("f1_first_data", data_out, 32'h0000_0011);
    chk("f1_still_full", in_ready, 0);
    step();
    chk("f1_slot_free", in_ready, 1);
    chk("f1_held_pixel", in_data, 32'h0000_0055);
    feed_en = 1'b1;
    step();
    finish_frame(t, t + 40, -1);
    check_regular(t);
    chk("f1_fifth_pixel", (sdata_q.size() > 4) ? 64'(sdata_q[4]) : 64'hDEAD, 32'h0000_0055);
`ifdef UNDERRUN_CNT_EN
    chk("f1_ucnt", underrun_cnt, 0);
`endif

    // Frame 2: 4 leftover pixels, then 20 cycles of starvation
    feed_en  = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    chk("leftover_count", exp_q.size(), 4);
    chk("leftover_full", in_ready, 0);
    begin_frame(t);
    finish_frame(t, -1, t + 53);
    chk("f2_n_strobes", strobe_q.size(), 16);
    if (strobe_q.size() > 4) begin
      chk("f2_strobe4_before", strobe_q[3], t + 26);
      chk("f2_strobe5_after", strobe_q[4], t + 54);
    end
    chk("f2_done_cyc", fd_cyc, t + 151);
`ifdef UNDERRUN_CNT_EN
    chk("f2_ucnt", underrun_cnt, 20);
`endif

    // Frame 3: reset after the 7th strobe, then a complete frame
    begin_frame(t);
    while (strobe_q.size() < 7 && cyc < t + 100) step();
    chk("f3_seventh_cyc", (strobe_q.size() == 7) ? strobe_q[6] : -1, t + 50);
    fd0 = fd_cnt;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("f3_no_done", fd_cnt - fd0, 0);
    chk("f3_refilled", in_ready, 0);
    begin_frame(t);
    finish_frame(t, -1, -1);
    check_regular(t);

    // Frame 4: start and first push in the same cycle, FIFO empty
    feed_en  = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    step();
    chk("f4_empty_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 32'hCAFE_0029;
    feed_en  = 1'b1;
    begin_frame(t);
    finish_frame(t, -1, -1);
    check_regular(t);
    chk("f4_first_pix", (sdata_q.size() > 0) ? 64'(sdata_q[0]) : 64'hDEAD, 32'hCAFE_0029);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_stream_tx.md
FM_STREAM_TX -- requirements
Module: fm_stream_tx

Interface
REQ-001 The block SHALL use parameter FM_DEPTH, default 64: channels per pixel vector.
REQ-002 The block SHALL use parameter FM_WIDTH, default 56: square frame side, pixels per row and rows per frame.
REQ-003 The block SHALL use parameter PIXEL_GAP, default 8: cycles between emitted pixels, legal range 3..15.
REQ-004 The block SHALL have one clock and an asynchronous active-high reset, with the ports listed below.
- clk  input  1  the single clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL provide these ports:
- start  input  1  one-cycle pulse that begins a frame.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  upstream pixel accept.
- in_data  input  16 x FM_DEPTH  upstream pixel vector.
- mode_out  output  1  high while a frame is being streamed.
- verticle_sync  output  1  frame-start pulse.
- data_out_valid  output  1  pixel strobe.
- data_out  output  16 x FM_DEPTH  pixel vector.
- frame_done  output  1  end-of-frame pulse.
- busy  output  1  high when the state is not IDLE.

Function
REQ-006 The block SHALL contain a 4-entry pixel FIFO: push on in_valid&&in_ready; in_ready = (count<4), derived from registered count only, so a full FIFO refuses a push even when it pops that cycle.
REQ-007 The FIFO SHALL accept pushes in every state, so the frame can be preloaded in IDLE.
REQ-008 The FSM SHALL have states IDLE, SYNC, STREAM, DRAIN, DONE.
REQ-009 In IDLE, start SHALL move the FSM to SYNC; start is ignored in every other state.
REQ-010 SYNC SHALL last one cycle with verticle_sync=1, then move to STREAM; verticle_sync is 0 in every other state.
REQ-011 mode_out SHALL be 1 in SYNC, STREAM, DRAIN and DONE, and 0 in IDLE.
REQ-012 STREAM emission:
- gap counter gcnt loads 0 on SYNC.
- when gcnt==0 and the FIFO is non-empty: pop, drive data_out with the FIFO head, set data_out_valid=1 for exactly one cycle, load gcnt=PIXEL_GAP-1.
- when gcnt!=0: decrement gcnt.
REQ-013 When gcnt==0 and the FIFO is empty (underrun), the block SHALL hold gcnt at 0, emit nothing, and emit on the first cycle the FIFO becomes non-empty.
REQ-014 data_out SHALL hold its value between strobes and SHALL be cleared to 0 in IDLE.
REQ-015 The block SHALL keep pixel counters col (0..FM_WIDTH-1) and row (0..FM_WIDTH-1), both 0 on SYNC; col increments per emitted pixel and wraps, and row increments on col wrap.
REQ-016 After emitting the pixel at row=col=FM_WIDTH-1, the FSM SHALL enter DRAIN for exactly PIXEL_GAP cycles with no strobes, then enter DONE.
REQ-017 DONE SHALL last one cycle with frame_done=1, then return to IDLE.
REQ-018 Consecutive strobes SHALL be at least PIXEL_GAP cycles apart, and the first strobe SHALL come at least 1 cycle after verticle_sync.
REQ-019 FIFO entries left over at DONE SHALL be retained for the next frame.

Reset
REQ-020 On rst=1 the block SHALL asynchronously set: state IDLE; FIFO empty; gcnt, row and col 0; all outputs 0 except in_ready=1.
REQ-021 Reset asserted mid-frame SHALL abort the frame without a frame_done pulse.

Configuration
REQ-022 With UNDERRUN_CNT_EN defined, the block SHALL add output underrun_cnt [15:0]:
- increments once per cycle spent in REQ-013 underrun.
- saturates at 16'hFFFF.
- clears on SYNC and on rst.
REQ-023 Without UNDERRUN_CNT_EN, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Verification (FM_WIDTH=4, PIXEL_GAP=8, FM_DEPTH=2)
REQ-024 Preload 4 pixels, then pulse start at cycle T while refilling continuously -> verticle_sync at T+1, first strobe at T+2, subsequent strobes every 8 cycles, 16 strobes total, frame_done at last strobe+9, data in push order.
REQ-025 Push 5 pixels back-to-back while in IDLE -> in_ready low after the 4th accept, 5th held until a pop frees a slot, no data lost.
REQ-026 In STREAM, starve the FIFO for 20 cycles after gcnt reaches 0 -> no strobe for 20 cycles, strobe on the cycle after the next push; with UNDERRUN_CNT_EN, underrun_cnt=20.
REQ-027 Pulse start again during STREAM -> no second verticle_sync, row/col unaffected.
REQ-028 Assert rst after the 7th strobe -> all outputs 0 and in_ready=1 immediately, no frame_done; a following start produces a full 16-pixel frame.
REQ-029 Pulse start with start and in_valid asserted in the same cycle, FIFO empty -> verticle_sync next cycle, first strobe carries that pixel on the cycle after.
